// File: rtl/rst_pkg.sv
// Shared types for the staged reset-release sequencer.
package rst_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    SWHOLD  = 2'd3
  } rst_seq_state_e;

endpackage

// File: rtl/rst_seq_cnt.sv
// Hold counter: counts 0..HOLD_CYCLES-1 while enabled and wraps to 0.
// wrap is high while the count sits at its terminal value.
module rst_seq_cnt #(
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  logic [CNT_W-1:0] cnt_reg;

  assign wrap = (cnt_reg == CNT_W'(HOLD_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= wrap ? '0 : cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rst_seq.sv
// Staged reset-release sequencer: releases NUM active-low resets in index order,
// HOLD_CYCLES apart. Software re-run path compiled only with RST_SEQ_SWRST_EN.
module rst_seq
  import rst_pkg::*;
#(
  parameter int NUM         = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         swrst_req_i,
  output logic                         swrst_ack_o,
  output logic [NUM-1:0]               rst_n_o,
  output logic [$clog2(NUM+1)-1:0]     stage_o,
  output logic                         done_o
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int IDX_W = $clog2(NUM + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

  rst_seq_state_e   state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [NUM-1:0]   rst_n_reg;
  logic             done_reg;
  logic [NUM-1:0]   release_hit;
  logic             cnt_clr;
  logic             cnt_en;
  logic             wrap;

  // One-hot of the output selected by idx; OR-ed in so released bits stay high.
  generate
    for (genvar gi = 0; gi < NUM; gi++) begin : g_hit
      assign release_hit[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

`ifdef RST_SEQ_SWRST_EN
  logic sw_seq_reg;
  logic ack_reg;
  logic sw_start;

  assign sw_start    = (state_reg == RUN) && swrst_req_i;
  assign cnt_clr     = rst_i || sw_start;
  assign cnt_en      = (state_reg == RELEASE) || (state_reg == SWHOLD);
  assign swrst_ack_o = ack_reg;
`else
  wire unused_swrst = swrst_req_i;

  assign cnt_clr     = rst_i;
  assign cnt_en      = (state_reg == RELEASE);
  assign swrst_ack_o = 1'b0;
`endif

  rst_seq_cnt #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_cnt (
    .clk_i (clk_i),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .wrap  (wrap)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= RELEASE;
      idx_reg    <= '0;
      rst_n_reg  <= '0;
      done_reg   <= 1'b0;
`ifdef RST_SEQ_SWRST_EN
      sw_seq_reg <= 1'b0;
      ack_reg    <= 1'b0;
`endif
    end else begin
`ifdef RST_SEQ_SWRST_EN
      ack_reg <= 1'b0;
`endif
      case (state_reg)
        RELEASE: begin
          if (wrap) begin
            rst_n_reg <= rst_n_reg | release_hit;
            idx_reg   <= idx_reg + IDX_W'(1);
            if (idx_reg == LAST_IDX) begin
              state_reg <= RUN;
              done_reg  <= 1'b1;
`ifdef RST_SEQ_SWRST_EN
              // Only a software-initiated sequence acknowledges completion.
              ack_reg    <= sw_seq_reg;
              sw_seq_reg <= 1'b0;
`endif
            end
          end
        end
        RUN: begin
`ifdef RST_SEQ_SWRST_EN
          if (swrst_req_i) begin
            state_reg  <= SWHOLD;
            rst_n_reg  <= '0;
            done_reg   <= 1'b0;
            idx_reg    <= '0;
            sw_seq_reg <= 1'b1;
          end
`endif
        end
`ifdef RST_SEQ_SWRST_EN
        SWHOLD: begin
          if (wrap) begin
            state_reg <= RELEASE;
          end
        end
`endif
        default: begin
          state_reg <= RELEASE;
          idx_reg   <= '0;
          rst_n_reg <= '0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign rst_n_o = rst_n_reg;
  assign stage_o = idx_reg;
  assign done_o  = done_reg;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: two instances (NUM=4/HOLD=4 and NUM=3/HOLD=1) checked each
// cycle against a timing-formula model; honours RST_SEQ_SWRST_EN.
module tb_rst_seq;

`ifdef RST_SEQ_SWRST_EN
  localparam bit SW_EN = 1'b1;
`else
  localparam bit SW_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;

  logic [3:0] rst_n_a;
  logic [2:0] stage_a;
  logic       done_a;
  logic       ack_a;
  logic [2:0] rst_n_b;
  logic [1:0] stage_b;
  logic       done_b;
  logic       ack_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Per-instance model state: index 0 = u_a, 1 = u_b.
  int nums [2] = '{4, 3};
  int holds[2] = '{4, 1};
  bit m_in_rst[2] = '{1'b1, 1'b1};
  bit m_sw    [2] = '{1'b0, 1'b0};
  bit m_done  [2] = '{1'b0, 1'b0};
  int m_base  [2] = '{0, 0};
  int m_cnt   [2] = '{0, 0};
  bit m_ack   [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  rst_seq #(.NUM(4), .HOLD_CYCLES(4)) u_a (
    .clk_i       (clk),
    .rst_i       (rst),
    .swrst_req_i (req),
    .swrst_ack_o (ack_a),
    .rst_n_o     (rst_n_a),
    .stage_o     (stage_a),
    .done_o      (done_a)
  );

  rst_seq #(.NUM(3), .HOLD_CYCLES(1)) u_b (
    .clk_i       (clk),
    .rst_i       (rst),
    .swrst_req_i (req),
    .swrst_ack_o (ack_b),
    .rst_n_o     (rst_n_b),
    .stage_o     (stage_b),
    .done_o      (done_b)
  );

  // Outputs released e edges after the sequence origin.
  function automatic int released(bit sw, int e, int num, int h);
    int c;
    if (sw) c = (e < h) ? 0 : (e / h) - 1;
    else    c = (e + 1) / h;
    if (c > num) c = num;
    return c;
  endfunction

  task automatic model_edge(bit r, bit q);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_in_rst[i] = 1'b1;
      end else if (m_in_rst[i]) begin
        m_in_rst[i] = 1'b0;
        m_base[i]   = cyc;
        m_sw[i]     = 1'b0;
      end else if (SW_EN && m_done[i] && q) begin
        m_base[i] = cyc;
        m_sw[i]   = 1'b1;
      end
      if (m_in_rst[i]) begin
        m_cnt[i] = 0;
        m_ack[i] = 1'b0;
      end else begin
        m_cnt[i] = released(m_sw[i], cyc - m_base[i], nums[i], holds[i]);
        m_ack[i] = m_sw[i] && ((cyc - m_base[i]) == (nums[i] + 1) * holds[i]);
      end
      m_done[i] = (m_cnt[i] == nums[i]);
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(bit r, bit q);
    @(negedge clk);
    rst = r;
    req = q;
    @(posedge clk);
    cyc++;
    model_edge(r, q);
    #1;
    check("a_rst_n", 32'(rst_n_a), 32'((1 << m_cnt[0]) - 1));
    check("a_stage", 32'(stage_a), 32'(m_cnt[0]));
    check("a_done",  32'(done_a),  32'(m_done[0]));
    check("a_ack",   32'(ack_a),   32'(m_ack[0]));
    check("b_rst_n", 32'(rst_n_b), 32'((1 << m_cnt[1]) - 1));
    check("b_stage", 32'(stage_b), 32'(m_cnt[1]));
    check("b_done",  32'(done_b),  32'(m_done[1]));
    check("b_ack",   32'(ack_b),   32'(m_ack[1]));
  endtask

  initial begin
    $display("phase reset_hold cyc=%0d", cyc);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);

    $display("phase first_release_then_midseq_reset cyc=%0d", cyc);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);

    $display("phase sw_request_pulse cyc=%0d", cyc);
    step(1'b0, 1'b1);
    for (int i = 0; i < 26; i++) step(1'b0, 1'b0);

    $display("phase req_held_during_release cyc=%0d", cyc);
    step(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0);

    $display("phase reset_overrides_req cyc=%0d", cyc);
    step(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);

    $display("phase random cyc=%0d", cyc);
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 60) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
